lfsr_seq_gen: RTL and testbench

Parametrised LFSR sequence generator: the next generation of the two-tap 8-bit pseudo-random unit. It accepts an arbitrary tap mask, seed, step count and Fibonacci/Galois mode, and steps the register once per cycle until the requested count is reached. A `start`/`busy`/`done` handshake supports a top-level controller or switch/button front end. A registered `num_valid` strobe marks every new state so a display or checker can consume the whole sequence, not only the final value.

---
 rtl/lfsr_seq_gen.sv | 164 ++++++++++++++++
 tb/tb_lfsr_seq_gen.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_seq_gen.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_seq_gen
// Purpose  : Parametrised LFSR sequence generator. A start request captures
//            the tap mask, step count and mode, and loads the seed. The
//            register then steps once per cycle, Fibonacci or Galois, until
//            the requested number of steps has been taken. Each new state is
//            marked by a one-cycle num_valid strobe.
// Ports    : clk       - single clock, rising edge
//            rst       - synchronous active-high reset
//            start     - request, accepted only when idle
//            taps      - feedback mask (bit k includes register bit k)
//            seed      - initial register value
//            seq_num   - number of steps to run
//            mode      - 0 = Fibonacci, 1 = Galois
//            hold      - freezes stepping while high during a run
//            num       - current LFSR state (registered)
//            num_valid - high the cycle after each step
//            busy      - high from the cycle after acceptance until idle
//            done      - one-cycle completion pulse
//            err       - last accepted request had zero seed or zero taps
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_seq_gen #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] taps,
    input  logic [WIDTH-1:0] seed,
    input  logic [CNT_W-1:0] seq_num,
    input  logic             mode,
    input  logic             hold,
    output logic [WIDTH-1:0] num,
    output logic             num_valid,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_num;
    logic [WIDTH-1:0] w_num_nxt;
    logic [WIDTH-1:0] r_taps;
    logic [WIDTH-1:0] w_taps_nxt;
    logic [CNT_W-1:0] r_seq_num;
    logic [CNT_W-1:0] w_seq_num_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_mode;
    logic             w_mode_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic             r_num_valid;
    logic             w_num_valid_nxt;

    logic             w_fb;
    logic [WIDTH-1:0] w_fib_step;
    logic [WIDTH-1:0] w_gal_step;
    logic [WIDTH-1:0] w_num_step;
    logic             w_req_err;

    // One-step successors of the current state, using the captured taps/mode
    assign w_fb       = ^(r_num & r_taps);
    assign w_fib_step = {r_num[WIDTH-2:0], w_fb};
    assign w_gal_step = {r_num[WIDTH-2:0], 1'b0} ^ (r_num[WIDTH-1] ? r_taps : '0);
    assign w_num_step = r_mode ? w_gal_step : w_fib_step;

    // An all-zero seed or mask would lock the register at zero forever
    assign w_req_err  = (seed == '0) || (taps == '0);

    // The counter never exceeds the captured step count, so this cannot wrap
    assign w_cnt_inc  = r_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_num       <= '0;
            r_taps      <= '0;
            r_seq_num   <= '0;
            r_cnt       <= '0;
            r_mode      <= 1'b0;
            r_err       <= 1'b0;
            r_num_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_num       <= w_num_nxt;
            r_taps      <= w_taps_nxt;
            r_seq_num   <= w_seq_num_nxt;
            r_cnt       <= w_cnt_nxt;
            r_mode      <= w_mode_nxt;
            r_err       <= w_err_nxt;
            r_num_valid <= w_num_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_num_nxt       = r_num;
        w_taps_nxt      = r_taps;
        w_seq_num_nxt   = r_seq_num;
        w_cnt_nxt       = r_cnt;
        w_mode_nxt      = r_mode;
        w_err_nxt       = r_err;
        w_num_valid_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_taps_nxt    = taps;
                    w_seq_num_nxt = seq_num;
                    w_mode_nxt    = mode;
                    w_num_nxt     = seed;
                    w_cnt_nxt     = '0;
                    w_err_nxt     = w_req_err;
                    // Nothing to step: go straight to the completion cycle
                    if (w_req_err || (seq_num == '0)) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                if (!hold) begin
                    w_num_nxt       = w_num_step;
                    w_cnt_nxt       = w_cnt_inc;
                    w_num_valid_nxt = 1'b1;
                    if (w_cnt_inc == r_seq_num) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign num       = r_num;
    assign num_valid = r_num_valid;
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_seq_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_lfsr_seq_gen
// Purpose  : Self-checking bench for lfsr_seq_gen. Directed scenarios for the
//            documented sequences plus randomized requests checked against an
//            arithmetic reference model of the LFSR step rules.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_lfsr_seq_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] taps;
    logic [7:0] seed;
    logic [7:0] seq_num;
    logic       mode;
    logic       hold;
    logic [7:0] num;
    logic       num_valid;
    logic       busy;
    logic       done;
    logic       err;

    logic       start4;
    logic [3:0] taps4;
    logic [3:0] seed4;
    logic [7:0] seq_num4;
    logic       mode4;
    logic       hold4;
    logic [3:0] num4;
    logic       num_valid4;
    logic       busy4;
    logic       done4;
    logic       err4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lfsr_seq_gen #(.WIDTH(8), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .taps(taps), .seed(seed),
        .seq_num(seq_num), .mode(mode), .hold(hold), .num(num),
        .num_valid(num_valid), .busy(busy), .done(done), .err(err)
    );

    lfsr_seq_gen #(.WIDTH(4), .CNT_W(8)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .taps(taps4), .seed(seed4),
        .seq_num(seq_num4), .mode(mode4), .hold(hold4), .num(num4),
        .num_valid(num_valid4), .busy(busy4), .done(done4), .err(err4)
    );

    // Reference step: plain arithmetic on integers (shift = *2 mod 2^w)
    function automatic int model_next(int s, int t, bit m, int w);
        int full;
        int ones;
        int r;
        full = 1 << w;
        r    = (s * 2) % full;
        if (!m) begin
            ones = 0;
            for (int k = 0; k < w; k++)
                if (((s >> k) % 2 == 1) && ((t >> k) % 2 == 1)) ones++;
            r = r + (ones % 2);
        end else if (s >= (full / 2)) begin
            r = r ^ t;
        end
        return r;
    endfunction

    // Stimulus only: wait for idle, present a request for one edge, scramble inputs
    task automatic do_start(input logic [7:0] t, input logic [7:0] s,
                            input logic [7:0] n, input logic m);
        int w = 0;
        while (busy !== 1'b0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_wait: busy=%b required 0", busy);
        end
        taps = t; seed = s; seq_num = n; mode = m; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        taps = 8'($urandom); seed = 8'($urandom);
        seq_num = 8'($urandom); mode = 1'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; taps = 8'hB8; seed = 8'hAA; seq_num = 8'd3;
        mode = 1'b0; hold = 1'b0;
        start4 = 1'b0; taps4 = '0; seed4 = '0; seq_num4 = '0; mode4 = 1'b0; hold4 = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({num, num_valid, busy, done, err} !== 12'h000) begin
            errors++;
            $display("FAIL reset_state: got %h required 000", {num, num_valid, busy, done, err});
        end
        checks++;
        if ({num4, busy4, done4} !== 6'h00) begin
            errors++;
            $display("FAIL reset_state4: got %h required 00", {num4, busy4, done4});
        end
        start = 1'b0; rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fib_vector();
        logic [7:0] exp_v [5] = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23};
        int bcnt = 0;
        do_start(8'hB8, 8'h01, 8'd5, 1'b0);
        checks++;
        if ({num, num_valid, busy, done, err} !== {8'h01, 4'b0100}) begin
            errors++;
            $display("FAIL fib_accept: got %h required %h", {num, num_valid, busy, done, err}, {8'h01, 4'b0100});
        end
        for (int k = 0; k < 5; k++) begin
            bcnt += int'(busy);
            @(negedge clk);
            checks++;
            if ({num, num_valid, done} !== {exp_v[k], 1'b1, (k == 4)}) begin
                errors++;
                $display("FAIL fib_step%0d: num=%h nv=%b done=%b required %h 1 %b", k + 1, num, num_valid, done, exp_v[k], (k == 4));
            end
        end
        bcnt += int'(busy);
        @(negedge clk);
        checks++;
        if (bcnt != 6 || {num, busy, done, err} !== {8'h23, 3'b000}) begin
            errors++;
            $display("FAIL fib_end: busy_cycles=%0d num=%h busy=%b done=%b err=%b required 6 23 0 0 0", bcnt, num, busy, done, err);
        end
    endtask

    task automatic test_galois_vector();
        do_start(8'h1D, 8'h80, 8'd2, 1'b1);
        @(negedge clk);
        checks++;
        if ({num, num_valid, done} !== {8'h1D, 2'b10}) begin
            errors++;
            $display("FAIL gal_step1: got %h required %h", {num, num_valid, done}, {8'h1D, 2'b10});
        end
        @(negedge clk);
        checks++;
        if ({num, num_valid, done} !== {8'h3A, 2'b11}) begin
            errors++;
            $display("FAIL gal_step2: got %h required %h", {num, num_valid, done}, {8'h3A, 2'b11});
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({num, num_valid, busy, done} !== {8'h3A, 3'b000}) begin
            errors++;
            $display("FAIL gal_held: got %h required %h", {num, num_valid, busy, done}, {8'h3A, 3'b000});
        end
    endtask

    task automatic test_width4();
        int s = 1;
        logic [15:0] seen = '0;
        taps4 = 4'hC; seed4 = 4'h1; seq_num4 = 8'd15; mode4 = 1'b0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0; taps4 = 4'h3; seed4 = 4'h7;
        checks++;
        if ({num4, busy4} !== {4'h1, 1'b1}) begin
            errors++;
            $display("FAIL w4_accept: num=%h busy=%b required 1 1", num4, busy4);
        end
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            s = model_next(s, 12, 1'b0, 4);
            checks++;
            if ({num4, num_valid4} !== {s[3:0], 1'b1}) begin
                errors++;
                $display("FAIL w4_step%0d: num=%h nv=%b required %h 1", k, num4, num_valid4, s[3:0]);
            end
            checks++;
            if (num4 == 4'h0 || seen[num4]) begin
                errors++;
                $display("FAIL w4_distinct%0d: num=%h repeated or zero, required new nonzero", k, num4);
            end
            seen[num4] = 1'b1;
        end
        checks++;
        if ({num4, done4} !== {4'h1, 1'b1}) begin
            errors++;
            $display("FAIL w4_final: num=%h done=%b required 1 1", num4, done4);
        end
        @(negedge clk);
    endtask

    task automatic test_hold();
        int bcnt = 0;
        logic [7:0] exp_n [5] = '{8'h03, 8'h03, 8'h03, 8'h06, 8'h0D};
        logic       exp_h [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        do_start(8'h03, 8'h01, 8'd3, 1'b0);
        for (int k = 0; k < 5; k++) begin
            hold = exp_h[k];
            bcnt += int'(busy);
            @(negedge clk);
            checks++;
            if ({num, num_valid, busy, done} !== {exp_n[k], !exp_h[k], 1'b1, (k == 4)}) begin
                errors++;
                $display("FAIL hold_cyc%0d: got %h required %h", k, {num, num_valid, busy, done}, {exp_n[k], !exp_h[k], 1'b1, (k == 4)});
            end
        end
        hold = 1'b0;
        bcnt += int'(busy);
        @(negedge clk);
        checks++;
        if (bcnt != 6 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_busy: busy_cycles=%0d busy=%b required 6 0", bcnt, busy);
        end
    endtask

    task automatic test_err();
        do_start(8'hB8, 8'h00, 8'd4, 1'b0);
        checks++;
        if ({num, num_valid, busy, done, err} !== {8'h00, 4'b0111}) begin
            errors++;
            $display("FAIL err_accept: got %h required %h", {num, num_valid, busy, done, err}, {8'h00, 4'b0111});
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({num_valid, busy, done, err} !== 4'b0001) begin
            errors++;
            $display("FAIL err_held: got %b required 0001", {num_valid, busy, done, err});
        end
        do_start(8'hB8, 8'h01, 8'd1, 1'b0);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: err=%b required 0", err);
        end
        repeat (2) @(negedge clk);
        do_start(8'h00, 8'h5A, 8'd3, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({num, err} !== 9'h000) begin
            errors++;
            $display("FAIL err_reset: num=%h err=%b required 00 0", num, err);
        end
    endtask

    task automatic test_zero_and_ignore();
        logic [7:0] exp_v [4] = '{8'h02, 8'h04, 8'h08, 8'h11};
        do_start(8'h1D, 8'h5A, 8'd0, 1'b1);
        checks++;
        if ({num, num_valid, busy, done, err} !== {8'h5A, 4'b0110}) begin
            errors++;
            $display("FAIL zero_accept: got %h required %h", {num, num_valid, busy, done, err}, {8'h5A, 4'b0110});
        end
        @(negedge clk);
        checks++;
        if ({num, num_valid, busy, done} !== {8'h5A, 3'b000}) begin
            errors++;
            $display("FAIL zero_idle: got %h required %h", {num, num_valid, busy, done}, {8'h5A, 3'b000});
        end
        do_start(8'hB8, 8'h01, 8'd4, 1'b0);
        for (int k = 0; k < 4; k++) begin
            start = (k < 2);
            seed = 8'hFF; taps = 8'h1D; seq_num = 8'd9; mode = 1'b1;
            @(negedge clk);
            checks++;
            if ({num, num_valid, done} !== {exp_v[k], 1'b1, (k == 3)}) begin
                errors++;
                $display("FAIL ignore_step%0d: got %h required %h", k + 1, {num, num_valid, done}, {exp_v[k], 1'b1, (k == 3)});
            end
        end
        start = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({num, busy} !== {8'h11, 1'b0}) begin
                errors++;
                $display("FAIL ignore_noqueue: num=%h busy=%b required 11 0", num, busy);
            end
        end
    endtask

    task automatic test_rst_mid();
        do_start(8'hB8, 8'h01, 8'd10, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({num, num_valid, busy, done, err} !== 12'h000) begin
            errors++;
            $display("FAIL rst_mid: got %h required 000", {num, num_valid, busy, done, err});
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({num_valid, busy, done} !== 3'b000) begin
                errors++;
                $display("FAIL rst_after: got %b required 000", {num_valid, busy, done});
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            int t, s, n, exp_s, steps, cyc;
            bit m, e_err, h;
            t = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(0, 255));
            s = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(0, 255));
            n = (it % 8 == 7) ? 0 : int'($urandom_range(1, 20));
            m = 1'($urandom_range(0, 1));
            e_err = (s == 0) || (t == 0);
            exp_s = s;
            do_start(8'(t), 8'(s), 8'(n), m);
            checks++;
            if ({num, num_valid, busy, done, err} !== {8'(s), 1'b0, 1'b1, (e_err || n == 0), e_err}) begin
                errors++;
                $display("FAIL rnd%0d_accept: got %h required %h", it, {num, num_valid, busy, done, err}, {8'(s), 1'b0, 1'b1, (e_err || n == 0), e_err});
            end
            steps = 0;
            cyc = 0;
            while (!e_err && steps < n && cyc < 200) begin
                h = ($urandom_range(0, 3) == 0);
                hold = h;
                @(negedge clk);
                hold = 1'b0;
                cyc++;
                if (!h) begin
                    exp_s = model_next(exp_s, t, m, 8);
                    steps++;
                end
                checks++;
                if ({num, num_valid, busy, done, err} !== {8'(exp_s), !h, 1'b1, (steps == n), 1'b0}) begin
                    errors++;
                    $display("FAIL rnd%0d_cyc%0d: got %h required %h", it, cyc, {num, num_valid, busy, done, err}, {8'(exp_s), !h, 1'b1, (steps == n), 1'b0});
                end
            end
            @(negedge clk);
            checks++;
            if ({num, num_valid, busy, done, err} !== {8'(exp_s), 3'b000, e_err}) begin
                errors++;
                $display("FAIL rnd%0d_end: got %h required %h", it, {num, num_valid, busy, done, err}, {8'(exp_s), 3'b000, e_err});
            end
        end
    endtask

    initial begin
        test_reset();
        test_fib_vector();
        test_galois_vector();
        test_width4();
        test_hold();
        test_err();
        test_zero_and_ignore();
        test_rst_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
